// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block response path: bus status codes,
// the response FSM states and a wait-counter sizing helper.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        OKAY         = 2'b00,
        DECODE_ERROR = 2'b01,
        SLAVE_ERROR  = 2'b10
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } rggen_response_state;

    // The counter must be able to hold WAIT_CYCLES-1; never narrower than one bit.
    function automatic int wait_counter_width(int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rggen_read_data_selector.sv
// Combinational mask-and-OR of per-register read data; multi-hot selects
// OR their lanes together.
module rggen_read_data_selector #(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1
) (
    input  logic [TOTAL_REGISTERS-1:0] i_select,
    input  logic [DATA_WIDTH-1:0]      i_read_data [TOTAL_REGISTERS],
    output logic [DATA_WIDTH-1:0]      o_read_data
);

    logic [DATA_WIDTH-1:0] masked [TOTAL_REGISTERS];

    for (genvar g = 0; g < TOTAL_REGISTERS; g++) begin : g_lane
        assign masked[g] = i_read_data[g] & {DATA_WIDTH{i_select[g]}};
    end

    always_comb begin
        o_read_data = '0;
        for (int i = 0; i < TOTAL_REGISTERS; i++) begin
            o_read_data = o_read_data | masked[i];
        end
    end

endmodule

// File: rtl/rggen_response_controller.sv
// Response stage: optional wait states, status/data capture, and a response
// held under valid/ready until the bridge accepts it.
module rggen_response_controller
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int WAIT_CYCLES     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_command_valid,
    input  logic                       i_read,
    output logic                       o_response_valid,
    input  logic                       i_response_ready,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic [1:0]                 o_status,
    input  logic [TOTAL_REGISTERS-1:0] i_register_select,
    input  logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS],
    input  logic [TOTAL_REGISTERS-1:0] i_register_error
);

    localparam int CW   = wait_counter_width(WAIT_CYCLES);
    localparam int LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LOAD = LOAD[CW-1:0];

    rggen_response_state   state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    rggen_status           status_q, status_next;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] sample_data;
    rggen_status           sample_status;

    rggen_read_data_selector #(
        .DATA_WIDTH      (DATA_WIDTH),
        .TOTAL_REGISTERS (TOTAL_REGISTERS)
    ) u_selector (
        .i_select    (i_register_select),
        .i_read_data (i_register_read_data),
        .o_read_data (sel_data)
    );

    // Decode error outranks slave error; data only survives a clean read.
    always_comb begin
        sample_status = OKAY;
        if (i_register_select == '0) begin
            sample_status = DECODE_ERROR;
        end else if ((i_register_select & i_register_error) != '0) begin
            sample_status = SLAVE_ERROR;
        end
        sample_data = (i_read && (sample_status == OKAY)) ? sel_data : '0;
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        data_next   = data_q;
        status_next = status_q;
        case (state)
            IDLE: begin
                if (i_command_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next  = RESPOND;
                        data_next   = sample_data;
                        status_next = sample_status;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // A withdrawn command abandons the access without a response.
                if (!i_command_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next  = RESPOND;
                    data_next   = sample_data;
                    status_next = sample_status;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESPOND: begin
                if (i_response_ready) begin
                    state_next  = IDLE;
                    data_next   = '0;
                    status_next = OKAY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            status_q <= OKAY;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_q   <= data_next;
            status_q <= status_next;
        end
    end

    assign o_response_valid = (state == RESPOND);
    assign o_read_data      = data_q;
    assign o_status         = status_q;

endmodule

// File: tb/tb_rggen_response_controller.sv
// Bench for rggen_response_controller: three instances (0, 3 and 4 wait
// states) share register-side inputs; each has its own handshake signals.
module tb_rggen_response_controller;

    localparam int DW = 32;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd;
    logic [NR-1:0] sel, err;
    logic [DW-1:0] lanes [NR];

    logic          cv   [3];
    logic          rdy  [3];
    logic          rv   [3];
    logic [DW-1:0] rdat [3];
    logic [1:0]    stat [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_response_controller #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv[0]), .i_read(rd),
        .o_response_valid(rv[0]), .i_response_ready(rdy[0]), .o_read_data(rdat[0]),
        .o_status(stat[0]), .i_register_select(sel), .i_register_read_data(lanes),
        .i_register_error(err));

    rggen_response_controller #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv[1]), .i_read(rd),
        .o_response_valid(rv[1]), .i_response_ready(rdy[1]), .o_read_data(rdat[1]),
        .o_status(stat[1]), .i_register_select(sel), .i_register_read_data(lanes),
        .i_register_error(err));

    rggen_response_controller #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv[2]), .i_read(rd),
        .o_response_valid(rv[2]), .i_response_ready(rdy[2]), .o_read_data(rdat[2]),
        .o_status(stat[2]), .i_register_select(sel), .i_register_read_data(lanes),
        .i_register_error(err));

    function automatic int wc(int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: decode error if nothing selected, slave error if any selected
    // register flags an error, otherwise OKAY; reads return the OR of selected lanes.
    task automatic model(output logic [31:0] d, output logic [1:0] s);
        d = '0;
        if (sel == '0) s = 2'b01;
        else if ((sel & err) != '0) s = 2'b10;
        else begin
            s = 2'b00;
            if (rd) for (int i = 0; i < NR; i++) if (sel[i]) d = d | lanes[i];
        end
    endtask

    task automatic scramble_inputs();
        rd  = 1'($urandom);
        sel = 4'($urandom);
        err = 4'($urandom);
        for (int i = 0; i < NR; i++) lanes[i] = $urandom;
    endtask

    // Called at a negedge. The command is raised now; valid must appear after
    // wc(k)+1 edges and last hold+1 cycles, then everything returns to zero.
    task automatic transact(int k, int hold, bit early, bit scramble,
                            logic [31:0] ed, logic [1:0] es, string tag);
        cv[k]  = 1'b1;
        rdy[k] = early;
        for (int c = 1; c <= wc(k); c++) begin
            @(negedge clk);
            chk({tag, "_wait_valid"}, 32'(rv[k]), 32'd0);
        end
        for (int v = 0; v <= hold; v++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(rv[k]), 32'd1);
            chk({tag, "_data"}, rdat[k], ed);
            chk({tag, "_status"}, 32'(stat[k]), 32'(es));
            if (scramble) scramble_inputs();
            if (v == hold) begin
                rdy[k] = 1'b1;
                cv[k]  = 1'b0;
            end
        end
        @(negedge clk);
        rdy[k] = 1'b0;
        chk({tag, "_post_valid"}, 32'(rv[k]), 32'd0);
        chk({tag, "_post_data"}, rdat[k], 32'd0);
        chk({tag, "_post_status"}, 32'(stat[k]), 32'd0);
    endtask

    typedef struct {
        int          k;
        logic        rd;
        logic [3:0]  sel;
        logic [3:0]  err;
        logic [31:0] l0, l1, l2, l3;
        int          hold;
        bit          early;
        logic [31:0] ed;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] ed;
        logic [1:0]  es;
        int          hold;

        tbl[0] = '{0, 1'b1, 4'b0100, 4'b0000, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1'b1, 32'hDEADBEEF, 2'b00};
        tbl[1] = '{1, 1'b1, 4'b0001, 4'b0000, 32'hA5A50001, 32'h1, 32'h2, 32'h3, 5, 1'b0, 32'hA5A50001, 2'b00};
        tbl[2] = '{0, 1'b1, 4'b0000, 4'b0000, 32'h11, 32'h22, 32'h33, 32'h44, 0, 1'b0, 32'h0, 2'b01};
        tbl[3] = '{0, 1'b0, 4'b0010, 4'b0010, 32'h11, 32'h22, 32'h33, 32'h44, 1, 1'b0, 32'h0, 2'b10};
        tbl[4] = '{1, 1'b1, 4'b0011, 4'b0000, 32'h000000F0, 32'h0000000F, 32'hFF00, 32'h0, 0, 1'b0, 32'h000000FF, 2'b00};
        tbl[5] = '{2, 1'b1, 4'b1000, 4'b0100, 32'h1, 32'h2, 32'h4, 32'hCAFE0008, 2, 1'b0, 32'hCAFE0008, 2'b00};
        tbl[6] = '{0, 1'b1, 4'b0110, 4'b0100, 32'h1, 32'h2, 32'h4, 32'h8, 0, 1'b1, 32'h0, 2'b10};
        tbl[7] = '{0, 1'b0, 4'b0001, 4'b0000, 32'h5555AAAA, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'h0, 2'b00};

        for (int k = 0; k < 3; k++) begin
            cv[k]  = 1'b0;
            rdy[k] = 1'b0;
        end
        rd  = 1'b0;
        sel = '0;
        err = '0;
        for (int i = 0; i < NR; i++) lanes[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", 32'(rv[k]), 32'd0);
            chk("reset_data", rdat[k], 32'd0);
            chk("reset_status", 32'(stat[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int t = 0; t < 8; t++) begin
            rd       = tbl[t].rd;
            sel      = tbl[t].sel;
            err      = tbl[t].err;
            lanes[0] = tbl[t].l0;
            lanes[1] = tbl[t].l1;
            lanes[2] = tbl[t].l2;
            lanes[3] = tbl[t].l3;
            transact(tbl[t].k, tbl[t].hold, tbl[t].early, tbl[t].hold > 0,
                     tbl[t].ed, tbl[t].es, $sformatf("vec%0d", t));
        end

        // Command withdrawn in the second wait cycle: no response may follow
        rd = 1'b1; sel = 4'b0001; err = '0; lanes[0] = 32'h0BADF00D;
        cv[2] = 1'b1;
        @(negedge clk);
        chk("abort_wait1_valid", 32'(rv[2]), 32'd0);
        @(negedge clk);
        chk("abort_wait2_valid", 32'(rv[2]), 32'd0);
        cv[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_idle_valid", 32'(rv[2]), 32'd0);
        end
        model(ed, es);
        transact(2, 1, 1'b0, 1'b0, ed, es, "after_abort");

        // Reset asserted while a response is pending
        rd = 1'b1; sel = 4'b0001; err = '0; lanes[0] = 32'h12345678;
        cv[0] = 1'b1;
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("rstresp_valid", 32'(rv[0]), 32'd1);
        chk("rstresp_data", rdat[0], 32'h12345678);
        #2 rst_n = 1'b0;
        #1;
        chk("rstresp_async_valid", 32'(rv[0]), 32'd0);
        chk("rstresp_async_data", rdat[0], 32'd0);
        chk("rstresp_async_status", 32'(stat[0]), 32'd0);
        cv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstresp_idle_valid", 32'(rv[0]), 32'd0);
        model(ed, es);
        transact(0, 0, 1'b0, 1'b0, ed, es, "after_reset");

        // Randomised transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            scramble_inputs();
            if ($urandom_range(0, 7) == 0) sel = '0;
            err  = err & 4'($urandom);
            hold = $urandom_range(0, 3);
            model(ed, es);
            transact($urandom_range(0, 2), hold, (hold == 0) && 1'($urandom), 1'b1,
                     ed, es, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rggen_response_controller.md
# rggen_response_controller

Parametrised response stage of the register block, between the address decoder/register array and the bus-protocol bridge. It takes the per-register select and read-data vectors, optionally waits a configurable number of cycles before sampling, and builds read data and a 2-bit status. It presents the response with a valid/ready handshake so the bridge can apply backpressure. This adds programmable wait states, per-register error reporting and response hold-until-accept to the single-cycle response path.

## Interface
- DATA_WIDTH, 32, read-data width in bits (≥ 8)
- TOTAL_REGISTERS, 1, number of register select/data/error lanes (≥ 1)
- WAIT_CYCLES, 0, extra cycles between command acceptance and sampling (0–255)

- clk  input  1  sole clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_command_valid  input  1  command present; held by bridge until response handshake
- i_read  input  1  1 = read, 0 = write; stable while i_command_valid
- o_response_valid  output  1  response available
- i_response_ready  input  1  bridge accepts response
- o_read_data  output  DATA_WIDTH  read data; zero for writes and errors
- o_status  output  2  00 OKAY, 01 decode error (no select), 10 slave error (register-reported)
- i_register_select  input  TOTAL_REGISTERS  one bit per register, decoder output
- i_register_read_data  input  DATA_WIDTH × TOTAL_REGISTERS (unpacked array)  per-register read value
- i_register_error  input  TOTAL_REGISTERS  per-register access error flag

## Operation
- FSM states: IDLE, WAIT, RESPOND. Reset state is IDLE.
- IDLE:
  - If i_command_valid and WAIT_CYCLES==0, sample and go to RESPOND.
  - If i_command_valid and WAIT_CYCLES>0, load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter is 0, sample and go to RESPOND.
  - If i_command_valid drops during WAIT, abort to IDLE with no response.
- Sampling:
  - Status: 01 if no select bit is set. Otherwise 10 if (select & error) is nonzero. Otherwise 00.
  - Data: if i_read and status is 00, the OR of all select-masked read-data lanes; otherwise 0.
  - Multi-hot select is legal; data is OR-combined and errors are OR-combined.
- RESPOND:
  - o_response_valid=1; o_read_data and o_status are held stable.
  - On i_response_ready, go to IDLE and clear the data and status registers to 0 at that edge.
  - i_command_valid is ignored in RESPOND.
- Outside RESPOND: o_response_valid=0, o_read_data=0, o_status=00.
- The wait counter is $clog2(WAIT_CYCLES+1) bits wide, minimum 1 bit. It never wraps, because loading only happens in IDLE.

## Timing
- Reset values: o_response_valid=0, o_read_data=0, o_status=00, state IDLE, counter 0. Reset mid-WAIT or mid-RESPOND drops the transaction immediately.
- Latency from the first cycle i_command_valid is high in IDLE to o_response_valid high is WAIT_CYCLES+1 cycles. Select, data and error are sampled on the last edge of that interval.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Handshake: the transfer completes on a rising edge with o_response_valid && i_response_ready.
  - o_response_valid falls the next cycle.
  - A new command is accepted at the earliest one cycle after the handshake, because IDLE is always visited.
- Minimum back-to-back period is WAIT_CYCLES+2 cycles.
- i_response_ready may be high before valid; a response with ready already high lasts exactly one cycle.

## Structure
- Shared package rggen_rtl_pkg:
  - typedef enum logic [1:0] rggen_status {OKAY=2'b00, DECODE_ERROR=2'b01, SLAVE_ERROR=2'b10}.
  - FSM state enum rggen_response_state.
- Sub-module rggen_read_data_selector: combinational mask-and-OR over TOTAL_REGISTERS lanes, parametrised by DATA_WIDTH and TOTAL_REGISTERS. It is reused by future bridges.
- The controller holds the FSM, wait counter, and status/data registers.

## Test plan
- WAIT_CYCLES=0, TOTAL_REGISTERS=4, read with select=0100, lane2=0xDEADBEEF, ready held 1 → valid in cycle 1 for one cycle, data 0xDEADBEEF, status 00.
- WAIT_CYCLES=3, read with select=0001, ready held 0 for 5 cycles then 1 → valid rises 4 cycles after command and data is stable for all 6 valid cycles; after handshake, data=0 and status=00.
- Read with select=0000 → status 01, data 0. Write with select=0010 and error=0010 → status 10, data 0.
- Multi-hot select=0011, lane0=0x0000_00F0, lane1=0x0000_000F → data 0x0000_00FF, status 00.
- WAIT_CYCLES=4, drop i_command_valid in the second WAIT cycle → no valid; the next command is accepted normally.
- Assert rst_n low while in RESPOND with data 0x12345678 → outputs go to 0/00 asynchronously before the next edge; the FSM restarts in IDLE after release.
